// File: rtl/bf_runctl_pkg.sv
// bf_runctl shared widths and run-controller state encoding.
// BF_TAPE_CLEAR_EN selects whether a load is followed by a tape wipe.
package bf_runctl_pkg;

  localparam int CADDR_WIDTH = 13;
  localparam int DADDR_WIDTH = 15;
  localparam int DATA_WIDTH  = 8;

  typedef enum logic [2:0] {
    BF_ST_IDLE  = 3'd0,
    BF_ST_LOAD  = 3'd1,
    BF_ST_CLEAR = 3'd2,
    BF_ST_RUN   = 3'd3,
    BF_ST_DONE  = 3'd4
  } bf_state_t;

`ifdef BF_TAPE_CLEAR_EN
  localparam bf_state_t BF_ST_POSTLOAD = BF_ST_CLEAR;
`else
  localparam bf_state_t BF_ST_POSTLOAD = BF_ST_RUN;
`endif

endpackage

// File: rtl/bf_runctl_if.sv
// Host program-byte stream into the bf1 run controller.
// Master is the host link, slave is bf_runctl.
interface bf_runctl_if;

  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/bf_runctl.sv
// bf1 run controller: program load, optional tape wipe, core run, readback.
// Define BF_TAPE_CLEAR_EN to zero the tape between load and run.
module bf_runctl
  import bf_runctl_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetq,
  bf_runctl_if.slave             ld,
  input  logic                   abort,
  input  logic [DADDR_WIDTH-1:0] host_addr,
  output logic                   code_wr,
  output logic [CADDR_WIDTH-1:0] code_waddr,
  output logic [7:0]             code_wdata,
  output logic                   core_resetq,
  input  logic [CADDR_WIDTH-1:0] core_code_addr,
  input  logic [DADDR_WIDTH-1:0] core_mem_addr,
  input  logic                   core_mem_wr,
  input  logic [DATA_WIDTH-1:0]  core_mem_dout,
  output logic [DADDR_WIDTH-1:0] tape_addr,
  output logic                   tape_wr,
  output logic [DATA_WIDTH-1:0]  tape_dout,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [CADDR_WIDTH:0]   prog_len,
  output logic [31:0]            run_cycles
);

  bf_state_t              r_state;
  bf_state_t              w_next;
  logic                   r_core_resetq;
  logic                   r_done;
  logic                   r_overflow;
  logic [CADDR_WIDTH:0]   r_prog_len;
  logic [31:0]            r_run_cycles;
`ifdef BF_TAPE_CLEAR_EN
  logic [DADDR_WIDTH-1:0] r_clr_cnt;
  logic                   w_clr;
`endif

  logic w_host;
  logic w_load;
  logic w_run;
  logic w_hs;
  logic w_full;
  logic w_last;
  logic w_ovf;
  logic w_eop;

  assign w_host = (r_state == BF_ST_IDLE)
               || (r_state == BF_ST_DONE);
  assign w_load = (r_state == BF_ST_LOAD);
  assign w_run  = (r_state == BF_ST_RUN);
`ifdef BF_TAPE_CLEAR_EN
  assign w_clr  = (r_state == BF_ST_CLEAR);
`endif

  assign ld.ld_ready = (w_host || w_load) && !abort;
  assign w_hs        = ld.ld_valid && ld.ld_ready;

  // Last code RAM slot forces end of load even without ld_last.
  assign w_full = (r_prog_len[CADDR_WIDTH-1:0] == '1);
  assign w_last = ld.ld_last || (w_load && w_full);
  assign w_ovf  = w_hs && w_load && w_full && !ld.ld_last;

  // A full-size program has no reachable end address.
  assign w_eop = !r_prog_len[CADDR_WIDTH]
              && (core_code_addr == r_prog_len[CADDR_WIDTH-1:0]);

  assign code_wr    = w_hs;
  assign code_wdata = ld.ld_data;
  assign code_waddr = w_load ? r_prog_len[CADDR_WIDTH-1:0] : '0;

  always_comb begin
    w_next = r_state;
    if (abort)
      w_next = BF_ST_IDLE;
    else if (w_hs && w_last)
      w_next = BF_ST_POSTLOAD;
    else if (w_hs)
      w_next = BF_ST_LOAD;
`ifdef BF_TAPE_CLEAR_EN
    else if (w_clr && (r_clr_cnt == '1))
      w_next = BF_ST_RUN;
`endif
    else if (w_run && w_eop)
      w_next = BF_ST_DONE;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state       <= BF_ST_IDLE;
      r_core_resetq <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_prog_len    <= '0;
      r_run_cycles  <= '0;
`ifdef BF_TAPE_CLEAR_EN
      r_clr_cnt     <= '0;
`endif
    end else begin
      r_state       <= w_next;
      r_core_resetq <= (w_next == BF_ST_RUN);

      if (abort || (w_hs && w_host))
        r_done <= 1'b0;
      else if (w_run && w_eop)
        r_done <= 1'b1;

      if (w_hs && w_host)
        r_prog_len <= 1;
      else if (w_hs)
        r_prog_len <= r_prog_len + 1'b1;

      if (w_hs && w_host)
        r_overflow <= 1'b0;
      else if (w_ovf)
        r_overflow <= 1'b1;

      // Abort freezes the counter, including the aborted RUN cycle.
      if (!abort) begin
        if ((w_next == BF_ST_RUN) && !w_run)
          r_run_cycles <= '0;
        else if (w_run && (r_run_cycles != '1))
          r_run_cycles <= r_run_cycles + 1'b1;
      end

`ifdef BF_TAPE_CLEAR_EN
      if (w_clr)
        r_clr_cnt <= r_clr_cnt + 1'b1;
      else
        r_clr_cnt <= '0;
`endif
    end
  end

  // Core mem_wr is only honoured while the core is out of reset.
  always_comb begin
    tape_addr = host_addr;
    tape_wr   = 1'b0;
    tape_dout = '0;
    unique case (1'b1)
      w_run: begin
        tape_addr = core_mem_addr;
        tape_wr   = core_mem_wr;
        tape_dout = core_mem_dout;
      end
`ifdef BF_TAPE_CLEAR_EN
      w_clr: begin
        tape_addr = r_clr_cnt;
        tape_wr   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (r_state == BF_ST_LOAD)
             || (r_state == BF_ST_CLEAR)
             || (r_state == BF_ST_RUN);

  assign core_resetq = r_core_resetq;
  assign done        = r_done;
  assign overflow    = r_overflow;
  assign prog_len    = r_prog_len;
  assign run_cycles  = r_run_cycles;

endmodule
